// File: rtl/ctr_phase_seq_pkg.sv
// rtl/ctr_phase_seq_pkg.sv - shared states, default parameters and helpers for the phase sequencer
package ctr_phase_seq_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Default parameter values used by the top level
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NPH   = 4;
  localparam int DEF_WRAP  = 1;

  // Completed-loop counter ceiling
  localparam logic [7:0] LOOPS_MAX = 8'hFF;

  // Increment that sticks at LOOPS_MAX instead of rolling over
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == LOOPS_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ctr_phase_seq_thr.sv
// rtl/ctr_phase_seq_thr.sv - per-phase threshold registers with write decode and combinational read
module ctr_phase_seq_thr
  import ctr_phase_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NPH   = DEF_NPH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [$clog2(NPH)-1:0]  idx,
  input  logic [WIDTH-1:0]        val,
  input  logic [$clog2(NPH)-1:0]  rd_idx,
  output logic [WIDTH-1:0]        rd_val
);

  logic [WIDTH-1:0] thr [NPH];
  logic             idx_ok;

  // Indices past the last phase exist only when NPH is not a power of two; drop them
  assign idx_ok = (int'(idx) < NPH);

  // Threshold storage; a write lands at the edge, so a same-cycle compare sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPH; i++) begin
        thr[i] <= '0;
      end
    end else if (we && idx_ok) begin
      thr[idx] <= val;
    end
  end

  // Current phase's threshold, read without a register stage
  assign rd_val = thr[rd_idx];

endmodule

// File: rtl/ctr_phase_seq.sv
// rtl/ctr_phase_seq.sv - phase sequencer: counts cycles and steps through per-phase thresholds
module ctr_phase_seq
  import ctr_phase_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NPH   = DEF_NPH,
  parameter int WRAP  = DEF_WRAP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    cfg_we,
  input  logic [$clog2(NPH)-1:0]  cfg_idx,
  input  logic [WIDTH-1:0]        cfg_val,
  output logic [WIDTH-1:0]        ctr,
  output logic [$clog2(NPH)-1:0]  phase,
  output logic                    hit,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              loops
);

  localparam int              PW         = $clog2(NPH);
  localparam logic [PW-1:0]   LAST_PHASE = PW'(NPH - 1);

  state_t            state;
  state_t            state_nx;
  logic [WIDTH-1:0]  ctr_nx;
  logic [PW-1:0]     phase_nx;
  logic              hit_nx;
  logic [7:0]        loops_nx;
  logic [WIDTH-1:0]  thr_cur;
  logic              match;

  ctr_phase_seq_thr #(
    .WIDTH (WIDTH),
    .NPH   (NPH)
  ) u_thr (
    .clk    (clk),
    .rst    (rst),
    .we     (cfg_we),
    .idx    (cfg_idx),
    .val    (cfg_val),
    .rd_idx (phase),
    .rd_val (thr_cur)
  );

  assign match = (ctr == thr_cur);

  // Next-state and next-output decode; stop beats both start and a threshold match
  always_comb begin
    state_nx = state;
    ctr_nx   = ctr;
    phase_nx = phase;
    hit_nx   = 1'b0;
    loops_nx = loops;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx = ST_RUN;
          ctr_nx   = '0;
          phase_nx = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nx = ST_IDLE;
        end else if (match) begin
          // Counter holds on a match so equal back-to-back thresholds fire on consecutive cycles
          hit_nx = 1'b1;
          if (phase != LAST_PHASE) begin
            phase_nx = phase + PW'(1);
          end else if (WRAP != 0) begin
            ctr_nx   = '0;
            phase_nx = '0;
            loops_nx = sat_inc8(loops);
          end else begin
            state_nx = ST_DONE;
          end
        end else begin
          ctr_nx = ctr + WIDTH'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State and output registers; busy/done are decoded from the next state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ctr   <= '0;
      phase <= '0;
      hit   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      loops <= '0;
    end else begin
      state <= state_nx;
      ctr   <= ctr_nx;
      phase <= phase_nx;
      hit   <= hit_nx;
      busy  <= (state_nx == ST_RUN);
      done  <= (state_nx == ST_DONE);
      loops <= loops_nx;
    end
  end

endmodule

// File: tb/tb_ctr_phase_seq.sv
// tb/tb_ctr_phase_seq.sv - scoreboard bench for ctr_phase_seq across four parameter sets
module tb_ctr_phase_seq;

  typedef struct {
    logic [31:0] c;
    logic [7:0]  ph;
    logic [7:0]  lp;
    logic        dn;
    logic        consec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];
  int   last_hit [4];

  logic        start_s [4];
  logic        stop_s  [4];
  logic        we_s    [4];
  logic [1:0]  idx_s   [4];
  logic [31:0] val_s   [4];

  logic [31:0] ctr0;
  logic [7:0]  ctr1;
  logic [3:0]  ctr2;
  logic [7:0]  ctr3;
  logic [1:0]  phase0, phase1, phase2, phase3;
  logic        hit0, hit1, hit2, hit3;
  logic        busy0, busy1, busy2, busy3;
  logic        done0, done1, done2, done3;
  logic [7:0]  loops0, loops1, loops2, loops3;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ctr_phase_seq #(.WIDTH(32), .NPH(4), .WRAP(0)) u0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .stop(stop_s[0]),
    .cfg_we(we_s[0]), .cfg_idx(idx_s[0]), .cfg_val(val_s[0]),
    .ctr(ctr0), .phase(phase0), .hit(hit0), .busy(busy0), .done(done0), .loops(loops0));

  ctr_phase_seq #(.WIDTH(8), .NPH(4), .WRAP(1)) u1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .stop(stop_s[1]),
    .cfg_we(we_s[1]), .cfg_idx(idx_s[1]), .cfg_val(val_s[1][7:0]),
    .ctr(ctr1), .phase(phase1), .hit(hit1), .busy(busy1), .done(done1), .loops(loops1));

  ctr_phase_seq #(.WIDTH(4), .NPH(4), .WRAP(0)) u2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .stop(stop_s[2]),
    .cfg_we(we_s[2]), .cfg_idx(idx_s[2]), .cfg_val(val_s[2][3:0]),
    .ctr(ctr2), .phase(phase2), .hit(hit2), .busy(busy2), .done(done2), .loops(loops2));

  ctr_phase_seq #(.WIDTH(8), .NPH(3), .WRAP(1)) u3 (
    .clk(clk), .rst(rst), .start(start_s[3]), .stop(stop_s[3]),
    .cfg_we(we_s[3]), .cfg_idx(idx_s[3]), .cfg_val(val_s[3][7:0]),
    .ctr(ctr3), .phase(phase3), .hit(hit3), .busy(busy3), .done(done3), .loops(loops3));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic push(input int id, input int c, input int ph, input int lp, input bit dn, input bit cs);
    exp_t e;
    e.c = 32'(c); e.ph = 8'(ph); e.lp = 8'(lp); e.dn = dn; e.consec = cs;
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic check_hit(input int id, input logic [31:0] c, input logic [7:0] ph,
                           input logic [7:0] lp, input logic dn);
    exp_t e;
    if (qsize(id) == 0) begin
      total++;
      bad++;
      $display("FAIL hit%0d_unexpected: got hit ctr=%0d phase=%0d want no hit", id, c, ph);
    end else begin
      case (id)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        default: e = q3.pop_front();
      endcase
      chk($sformatf("hit%0d_ctr", id), 64'(c), 64'(e.c));
      chk($sformatf("hit%0d_phase", id), 64'(ph), 64'(e.ph));
      chk($sformatf("hit%0d_loops", id), 64'(lp), 64'(e.lp));
      chk($sformatf("hit%0d_done", id), 64'(dn), 64'(e.dn));
      if (e.consec) chk($sformatf("hit%0d_consec_gap", id), 64'(cyc - last_hit[id]), 64'd1);
    end
    last_hit[id] = cyc;
  endtask

  // Scoreboard monitor: every hit pulse is matched against the next queued expectation
  always @(negedge clk) begin
    if (hit0 === 1'b1) check_hit(0, ctr0, {6'd0, phase0}, loops0, done0);
    if (hit1 === 1'b1) check_hit(1, {24'd0, ctr1}, {6'd0, phase1}, loops1, done1);
    if (hit2 === 1'b1) check_hit(2, {28'd0, ctr2}, {6'd0, phase2}, loops2, done2);
    if (hit3 === 1'b1) check_hit(3, {24'd0, ctr3}, {6'd0, phase3}, loops3, done3);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg(input int id, input int idx, input int val);
    we_s[id] = 1'b1; idx_s[id] = 2'(idx); val_s[id] = 32'(val);
    step();
    we_s[id] = 1'b0;
  endtask

  task automatic pulse_start(input int id);
    start_s[id] = 1'b1;
    step();
    start_s[id] = 1'b0;
  endtask

  task automatic pulse_stop(input int id);
    stop_s[id] = 1'b1;
    step();
    stop_s[id] = 1'b0;
  endtask

  task automatic wait_drain(input int id, input int budget);
    int n = 0;
    while (qsize(id) != 0 && n < budget) begin
      step();
      n++;
    end
    chk($sformatf("drain%0d_timeout_left", id), 64'(qsize(id)), 64'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0; stop_s[i] = 1'b0; we_s[i] = 1'b0;
      idx_s[i] = 2'd0; val_s[i] = 32'd0; last_hit[i] = 0;
    end
    step(); step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst_ctr0", 64'(ctr0), 64'd0);
    chk("rst_phase0", 64'(phase0), 64'd0);
    chk("rst_hit0", 64'(hit0), 64'd0);
    chk("rst_busy0", 64'(busy0), 64'd0);
    chk("rst_done0", 64'(done0), 64'd0);
    chk("rst_loops0", 64'(loops0), 64'd0);
    chk("rst_busy3", 64'(busy3), 64'd0);

    // one-shot, thr={2,5,5,10}
    cfg(0, 0, 2); cfg(0, 1, 5); cfg(0, 2, 5); cfg(0, 3, 10);
    push(0, 2, 1, 0, 0, 0);
    push(0, 5, 2, 0, 0, 0);
    push(0, 5, 3, 0, 0, 1);
    push(0, 10, 3, 0, 1, 0);
    pulse_start(0);
    chk("os_busy_after_start", 64'(busy0), 64'd1);
    chk("os_ctr_after_start", 64'(ctr0), 64'd0);
    wait_drain(0, 50);
    step();
    chk("os_done", 64'(done0), 64'd1);
    chk("os_busy_end", 64'(busy0), 64'd0);
    chk("os_ctr_end", 64'(ctr0), 64'd10);
    chk("os_phase_end", 64'(phase0), 64'd3);
    step(); step(); step();
    chk("os_ctr_hold", 64'(ctr0), 64'd10);
    chk("os_done_hold", 64'(done0), 64'd1);

    // stop together with start at ctr=4 phase 1
    push(0, 2, 1, 0, 0, 0);
    pulse_start(0);
    n = 0;
    while (!(ctr0 == 32'd4 && phase0 == 2'd1) && n < 20) begin step(); n++; end
    chk("stop_reach_ctr4_timeout", 64'(n < 20), 64'd1);
    start_s[0] = 1'b1; stop_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0; stop_s[0] = 1'b0;
    chk("stop_busy", 64'(busy0), 64'd0);
    chk("stop_ctr", 64'(ctr0), 64'd4);
    chk("stop_phase", 64'(phase0), 64'd1);
    chk("stop_done", 64'(done0), 64'd0);
    pulse_start(0);
    chk("restart_ctr", 64'(ctr0), 64'd0);
    chk("restart_phase", 64'(phase0), 64'd0);
    chk("restart_busy", 64'(busy0), 64'd1);
    // start held high while running must not restart the count
    start_s[0] = 1'b1;
    n = 0;
    while (ctr0 != 32'd2 && n < 10) begin step(); n++; end
    start_s[0] = 1'b0;
    chk("start_ignored_reach_ctr2", 64'(n < 10), 64'd1);
    pulse_stop(0);
    chk("stop_over_match_busy", 64'(busy0), 64'd0);
    chk("stop_over_match_ctr", 64'(ctr0), 64'd2);
    chk("stop_over_match_phase", 64'(phase0), 64'd0);
    step(); step();

    // loop mode, thr={1,3,4,6}, three loops
    cfg(1, 0, 1); cfg(1, 1, 3); cfg(1, 2, 4); cfg(1, 3, 6);
    for (int l = 0; l < 3; l++) begin
      push(1, 1, 1, l, 0, 0);
      push(1, 3, 2, l, 0, 0);
      push(1, 4, 3, l, 0, 0);
      push(1, 0, 0, l + 1, 0, 0);
    end
    pulse_start(1);
    wait_drain(1, 100);
    pulse_stop(1);
    chk("loop_loops3", 64'(loops1), 64'd3);
    chk("loop_ctr", 64'(ctr1), 64'd0);
    chk("loop_busy", 64'(busy1), 64'd0);
    chk("loop_done", 64'(done1), 64'd0);

    // WIDTH=4 counter wrap, thr={3,1,2,4}
    cfg(2, 0, 3); cfg(2, 1, 1); cfg(2, 2, 2); cfg(2, 3, 4);
    push(2, 3, 1, 0, 0, 0);
    push(2, 1, 2, 0, 0, 0);
    push(2, 2, 3, 0, 0, 0);
    push(2, 4, 3, 0, 1, 0);
    pulse_start(2);
    wait_drain(2, 60);
    step();
    chk("wrap4_done", 64'(done2), 64'd1);
    chk("wrap4_ctr", 64'(ctr2), 64'd4);

    // NPH=3: out-of-range write ignored, then saturating loop count with all thr=0
    cfg(3, 3, 7);
    chk("oor_ctr", 64'(ctr3), 64'd0);
    chk("oor_phase", 64'(phase3), 64'd0);
    chk("oor_busy", 64'(busy3), 64'd0);
    chk("oor_done", 64'(done3), 64'd0);
    chk("oor_loops", 64'(loops3), 64'd0);
    for (int l = 0; l < 258; l++) begin
      push(3, 0, 1, (l > 255) ? 255 : l, 0, 0);
      push(3, 0, 2, (l > 255) ? 255 : l, 0, 1);
      push(3, 0, 0, (l + 1 > 255) ? 255 : l + 1, 0, 1);
    end
    pulse_start(3);
    wait_drain(3, 1000);
    pulse_stop(3);
    chk("sat_loops", 64'(loops3), 64'd255);
    chk("sat_busy", 64'(busy3), 64'd0);

    // asynchronous reset mid-run
    pulse_start(0);
    step();
    chk("pre_rst_busy", 64'(busy0), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_ctr", 64'(ctr0), 64'd0);
    chk("arst_phase", 64'(phase0), 64'd0);
    chk("arst_hit", 64'(hit0), 64'd0);
    chk("arst_busy", 64'(busy0), 64'd0);
    chk("arst_done", 64'(done0), 64'd0);
    chk("arst_loops1", 64'(loops1), 64'd0);
    chk("arst_loops3", 64'(loops3), 64'd0);
    step();
    rst = 1'b0;
    step();
    push(0, 0, 1, 0, 0, 0);
    push(0, 0, 2, 0, 0, 1);
    push(0, 0, 3, 0, 0, 1);
    push(0, 0, 3, 0, 1, 1);
    pulse_start(0);
    step();
    chk("post_rst_first_hit", 64'(hit0), 64'd1);
    chk("post_rst_hit_ctr", 64'(ctr0), 64'd0);
    wait_drain(0, 20);
    step();
    chk("post_rst_done", 64'(done0), 64'd1);

    step(); step();
    chk("final_q_left", 64'(qsize(0) + qsize(1) + qsize(2) + qsize(3)), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
